// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: memop codes, FSM states,
// and the latched store-request bundle.
package mem_pkg;

  typedef enum logic [2:0] {
    MEMOP_W  = 3'b000,
    MEMOP_H  = 3'b001,
    MEMOP_HU = 3'b010,
    MEMOP_B  = 3'b011,
    MEMOP_BU = 3'b100
  } memop_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } st_fmt_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

endpackage

// File: rtl/mem_access_load_extract.sv
// Load formatter: picks byte/half lane from a memory word and extends it.
// Ports: rdata (raw word), op (memop), lane (addr[1:0]) -> data (for WB).
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{lane, 3'b000} +: 8];
  assign h = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    unique case (1'b1)
      (op == MEMOP_H):  data = {{16{h[15]}}, h};
      (op == MEMOP_HU): data = {16'h0, h};
      (op == MEMOP_B):  data = {{24{b[7]}}, b};
      (op == MEMOP_BU): data = {24'h0, b};
      default:          data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: req/ack data-memory transaction, store lane formatting,
// load extraction, pipeline stall and misaligned/illegal access flag.
// Ports: pipeline side (valid_in, memread, memwrite, memop, aluout,
// writedata -> stall, readdata, readdata_valid, addr_err) and data-memory
// side (dm_req, dm_we, dm_addr, dm_be, dm_wdata <- dm_rdata, dm_ack).
module mem_access
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        memop,
  input  logic [ADDR_W-1:0] aluout,
  input  logic [31:0]       writedata,
  output logic              stall,
  output logic [31:0]       readdata,
  output logic              readdata_valid,
  output logic              addr_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack
);

  state_e      state, state_nxt;
  logic        access, both, bad_op, bad_st;
  logic        is_word, is_half, misalign;
  logic        err, accept;
  logic [1:0]  lane;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] ext;
  st_fmt_t     st;

  assign lane     = aluout[1:0];
  assign access   = valid_in && (memread || memwrite);
  assign both     = memread && memwrite;
  assign bad_op   = !op_legal(memop);
  assign bad_st   = memwrite &&
                    (memop == MEMOP_HU || memop == MEMOP_BU);
  assign is_word  = memop == MEMOP_W;
  assign is_half  = memop == MEMOP_H || memop == MEMOP_HU;
  assign misalign = (is_half && lane[0]) ||
                    (is_word && lane != 2'b00);
  assign err      = access &&
                    (both || bad_op || bad_st || misalign);
  assign accept   = state == IDLE && access && !err;

  // Loads always fetch the full word; lanes are picked on return.
  always_comb begin
    st.be    = 4'b1111;
    st.wdata = writedata;
    if (memwrite) begin
      unique case (1'b1)
        (memop == MEMOP_B): begin
          st.be    = 4'b0001 << lane;
          st.wdata = {4{writedata[7:0]}};
        end
        (memop == MEMOP_H): begin
          st.be    = 4'b0011 << {lane[1], 1'b0};
          st.wdata = {2{writedata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_extract u_ext (
    .rdata (dm_rdata),
    .op    (op_q),
    .lane  (lane_q),
    .data  (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (dm_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall          = accept || state == BUSY;
    readdata_valid = state == DONE && !dm_we;
    addr_err       = state == IDLE && err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= 4'b0;
      dm_wdata <= 32'h0;
      op_q     <= 3'b0;
      lane_q   <= 2'b0;
      readdata <= 32'h0;
    end else if (accept) begin
      dm_req   <= 1'b1;
      dm_we    <= memwrite;
      dm_addr  <= {aluout[ADDR_W-1:2], 2'b00};
      dm_be    <= st.be;
      dm_wdata <= st.wdata;
      op_q     <= memop;
      lane_q   <= lane;
    end else if (state == BUSY && dm_ack) begin
      dm_req <= 1'b0;
      if (!dm_we) readdata <= ext;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: scoreboard of expected load data,
// per-feature tasks with inline comparisons.
module tb_mem_access;
  import mem_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_in = 1'b0;
  logic              memread = 1'b0;
  logic              memwrite = 1'b0;
  logic [2:0]        memop = 3'b0;
  logic [ADDR_W-1:0] aluout = '0;
  logic [31:0]       writedata = 32'h0;
  logic              stall;
  logic [31:0]       readdata;
  logic              readdata_valid;
  logic              addr_err;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata = 32'h0;
  logic              dm_ack = 1'b0;

  mem_access #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .memread        (memread),
    .memwrite       (memwrite),
    .memop          (memop),
    .aluout         (aluout),
    .writedata      (writedata),
    .stall          (stall),
    .readdata       (readdata),
    .readdata_valid (readdata_valid),
    .addr_err       (addr_err),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_be          (dm_be),
    .dm_wdata       (dm_wdata),
    .dm_rdata       (dm_rdata),
    .dm_ack         (dm_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] last_load = 32'h0;

  int          obs_stall, obs_req, obs_rv, obs_err, obs_rv_cyc;
  logic        obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_addr;

  // Drives one instruction for one cycle and plays the memory for
  // 12 cycles, acking after `delay` request cycles.
  task automatic run_access(input logic rd, input logic wr,
                            input logic [2:0] op,
                            input logic [31:0] addr,
                            input logic [31:0] wd,
                            input logic [31:0] rdat,
                            input int delay);
    int reqs;
    reqs = 0;
    obs_stall = 0; obs_req = 0; obs_rv = 0; obs_err = 0;
    obs_rv_cyc = -1;
    obs_we = 0; obs_be = 0; obs_wdata = 0; obs_addr = 0;
    @(negedge clk);
    valid_in = 1; memread = rd; memwrite = wr;
    memop = op; aluout = addr; writedata = wd; dm_rdata = rdat;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk);
        valid_in = 0; memread = 0; memwrite = 0;
      end
      dm_ack = dm_req && (reqs == delay);
      #1;
      if (stall) obs_stall++;
      if (addr_err) obs_err++;
      if (readdata_valid) begin
        obs_rv++;
        obs_rv_cyc = c;
        got_q.push_back(readdata);
      end
      if (dm_req) begin
        reqs++;
        obs_req++;
        obs_we = dm_we; obs_be = dm_be;
        obs_wdata = dm_wdata; obs_addr = dm_addr;
      end
    end
    dm_ack = 0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({dm_req, dm_we, dm_be, stall, readdata_valid, addr_err}
        !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0",
               {dm_req, dm_we, dm_be, stall, readdata_valid, addr_err});
    end
    n_checks++;
    if ({dm_addr, dm_wdata, readdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h expected 0",
               dm_addr, dm_wdata, readdata);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_lw();
    exp_q.push_back(32'hDEADBEEF);
    last_load = 32'hDEADBEEF;
    run_access(1, 0, MEMOP_W, 32'h100, 0, 32'hDEADBEEF, 0);
    n_checks++;
    if (obs_stall !== 2) begin
      n_fail++;
      $display("FAIL lw_stall: got %0d expected 2", obs_stall);
    end
    n_checks++;
    if (obs_rv_cyc !== 2 || obs_rv !== 1) begin
      n_fail++;
      $display("FAIL lw_rv: got cyc %0d n %0d expected 2 1",
               obs_rv_cyc, obs_rv);
    end
    n_checks++;
    if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 0) begin
      n_fail++;
      $display("FAIL lw_req: got %h %b %b expected 100 1111 0",
               obs_addr, obs_be, obs_we);
    end
    n_checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL lw_data: got none expected deadbeef");
    end else if (got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL lw_data: got %h expected %h", got_q[0], exp_q[0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_loads();
    logic [2:0]  ops [5] = '{MEMOP_B, MEMOP_BU, MEMOP_H,
                             MEMOP_HU, MEMOP_B};
    logic [31:0] adr [5] = '{32'h103, 32'h103, 32'h102,
                             32'h200, 32'h100};
    logic [31:0] exv [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                             32'h00007F01, 32'h00000001};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exv[i]);
      last_load = exv[i];
      run_access(1, 0, ops[i], adr[i], 0, 32'h80FF7F01, 0);
      n_checks++;
      if (got_q.size() != 1) begin
        n_fail++;
        $display("FAIL load%0d_count: got %0d expected 1",
                 i, got_q.size());
      end else if (got_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL load%0d_data: got %h expected %h",
                 i, got_q[0], exp_q[0]);
      end
      got_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_stores();
    logic [2:0]  ops [3] = '{MEMOP_B, MEMOP_H, MEMOP_W};
    logic [31:0] adr [3] = '{32'h101, 32'h102, 32'h104};
    logic [3:0]  ebe [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] ewd [3] = '{32'h78787878, 32'h56785678, 32'h12345678};
    logic [31:0] ead [3] = '{32'h100, 32'h100, 32'h104};
    for (int i = 0; i < 3; i++) begin
      run_access(0, 1, ops[i], adr[i], 32'h12345678, 32'h0, 0);
      n_checks++;
      if (obs_be !== ebe[i] || obs_wdata !== ewd[i]) begin
        n_fail++;
        $display("FAIL st%0d_lanes: got %b %h expected %b %h",
                 i, obs_be, obs_wdata, ebe[i], ewd[i]);
      end
      n_checks++;
      if (obs_addr !== ead[i] || obs_we !== 1 || obs_req !== 1) begin
        n_fail++;
        $display("FAIL st%0d_req: got %h %b %0d expected %h 1 1",
                 i, obs_addr, obs_we, obs_req, ead[i]);
      end
      n_checks++;
      if (obs_rv !== 0 || obs_stall !== 2) begin
        n_fail++;
        $display("FAIL st%0d_flow: got rv %0d stall %0d expected 0 2",
                 i, obs_rv, obs_stall);
      end
      got_q.delete();
    end
  endtask

  task automatic test_errors();
    logic        rds [5] = '{1, 0, 1, 1, 0};
    logic        wrs [5] = '{0, 1, 1, 0, 1};
    logic [2:0]  ops [5] = '{MEMOP_W, MEMOP_H, MEMOP_W,
                             3'b101, MEMOP_HU};
    logic [31:0] adr [5] = '{32'h102, 32'h001, 32'h100,
                             32'h100, 32'h100};
    for (int i = 0; i < 5; i++) begin
      run_access(rds[i], wrs[i], ops[i], adr[i],
                 32'hA5A5A5A5, 32'h11111111, 0);
      n_checks++;
      if (obs_err !== 1) begin
        n_fail++;
        $display("FAIL err%0d_pulse: got %0d expected 1", i, obs_err);
      end
      n_checks++;
      if (obs_req !== 0 || obs_stall !== 0 || obs_rv !== 0) begin
        n_fail++;
        $display("FAIL err%0d_quiet: got req %0d stall %0d rv %0d expected 0",
                 i, obs_req, obs_stall, obs_rv);
      end
      n_checks++;
      if (readdata !== last_load) begin
        n_fail++;
        $display("FAIL err%0d_hold: got %h expected %h",
                 i, readdata, last_load);
      end
      got_q.delete();
    end
  endtask

  task automatic test_delayed_ack();
    exp_q.push_back(32'hCAFEF00D);
    last_load = 32'hCAFEF00D;
    run_access(1, 0, MEMOP_W, 32'h40, 0, 32'hCAFEF00D, 5);
    n_checks++;
    if (obs_req !== 6 || obs_stall !== 7) begin
      n_fail++;
      $display("FAIL delay_len: got req %0d stall %0d expected 6 7",
               obs_req, obs_stall);
    end
    n_checks++;
    if (obs_rv_cyc !== 7 || got_q.size() != 1) begin
      n_fail++;
      $display("FAIL delay_rv: got cyc %0d n %0d expected 7 1",
               obs_rv_cyc, got_q.size());
    end else if (got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL delay_data: got %h expected %h",
               got_q[0], exp_q[0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    valid_in = 1; memread = 1; memwrite = 0;
    memop = MEMOP_W; aluout = 32'h200; dm_rdata = 32'h55AA55AA;
    dm_ack = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      valid_in = 0; memread = 0;
    end
    #1;
    n_checks++;
    if (dm_req !== 1 || stall !== 1) begin
      n_fail++;
      $display("FAIL rstmid_busy: got req %b stall %b expected 1 1",
               dm_req, stall);
    end
    rst_n = 0;
    #1;
    last_load = 32'h0;
    n_checks++;
    if (dm_req !== 0 || stall !== 0) begin
      n_fail++;
      $display("FAIL rstmid_drop: got req %b stall %b expected 0 0",
               dm_req, stall);
    end
    n_checks++;
    if (readdata !== last_load) begin
      n_fail++;
      $display("FAIL rstmid_rdata: got %h expected %h",
               readdata, last_load);
    end
    @(negedge clk);
    rst_n = 1;
    exp_q.push_back(32'h0000BEEF);
    last_load = 32'h0000BEEF;
    run_access(1, 0, MEMOP_HU, 32'h202, 0, 32'hBEEF1234, 1);
    n_checks++;
    if (got_q.size() != 1 || obs_stall !== 3) begin
      n_fail++;
      $display("FAIL recover_flow: got n %0d stall %0d expected 1 3",
               got_q.size(), obs_stall);
    end else if (got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL recover_data: got %h expected %h",
               got_q[0], exp_q[0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_errors();
    test_delayed_ack();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
